skew_feeder: RTL and testbench

- Systolic input staging stage that sits directly upstream of the smac/smul array in the dtpu datapath.
- Accepts one activation vector per beat (one DATA_WIDTH word per array row) over a valid/ready handshake and buffers it in a small FIFO.
- Emits the vector diagonally skewed: row i is delayed i advances. Drives the array clock-enable (ce).
- After the last beat, flushes NROWS-1 zero beats to drain the diagonal, then pulses done.

---
 rtl/dtpu_pkg.sv | 14 +
 rtl/skew_fifo.sv | 53 +++++
 rtl/skew_feeder.sv | 128 ++++++++++++
 tb/tb_skew_feeder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtpu_pkg.sv
// Shared types and helpers for the dtpu input staging path (skew_feeder, skew_fifo).
package dtpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} fsm_t;

  localparam int STAT_W = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/skew_fifo.sv
// Small synchronous FIFO for {last, data}. A word written at an edge becomes
// poppable one cycle later, modelling the write-to-read latency of the storage.
module skew_fifo
  import dtpu_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             avail
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             push_q;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // the entry written at the last edge is not yet readable
  assign avail = (count > {{PW{1'b0}}, push_q});
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/skew_feeder.sv
// Systolic input stager: buffers activation vectors, emits them diagonally skewed
// and drains with NROWS-1 zero beats. Optional counters: SKEW_FEEDER_STATS_EN.
module skew_feeder
  import dtpu_pkg::*;
#(
  parameter int NROWS      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [NROWS*DATA_WIDTH-1:0] s_data,
  input  logic                        s_last,
  input  logic                        stall_n,
  output logic [NROWS*DATA_WIDTH-1:0] m_data,
  output logic [NROWS-1:0]            m_lane_valid,
  output logic                        m_ce,
  output logic                        busy,
  output logic                        done
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [STAT_W-1:0]           stat_beats,
  output logic [STAT_W-1:0]           stat_stall
`endif
);
  localparam int VW = NROWS * DATA_WIDTH;
  localparam int CW = ptr_w(NROWS);

  logic [1:0]    rst_sync;
  logic          rst_n;
  fsm_t          state;
  logic [CW-1:0] flush_cnt;
  logic          push, pop, adv, full, empty, avail, lane_vld_in;
  logic [VW:0]   fifo_rdata;
  logic [VW-1:0] lane_in;

  // async assert, release synchronised to clk
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  assign s_ready     = !full && (state != FLUSH);
  assign push        = s_valid && s_ready;
  assign pop         = (state == STREAM) && stall_n && avail;
  assign adv         = pop || ((state == FLUSH) && stall_n);
  assign lane_in     = (state == FLUSH) ? '0 : fifo_rdata[VW-1:0];
  assign lane_vld_in = (state != FLUSH);
  assign busy        = (state != IDLE) || !empty;

  skew_fifo #(.WIDTH(VW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({s_last, s_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .avail (avail)
  );

  // lane i carries i+1 stages so each row lags the previous one by one advance
  for (genvar i = 0; i < NROWS; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] stg [i+1];
    logic [i:0]            vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) stg[k] <= '0;
        vld <= '0;
      end else if (adv) begin
        stg[0] <= lane_in[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        vld[0] <= lane_vld_in;
        for (int k = 1; k <= i; k++) begin
          stg[k] <= stg[k-1];
          vld[k] <= vld[k-1];
        end
      end
    end

    assign m_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = stg[i];
    assign m_lane_valid[i] = vld[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      m_ce      <= 1'b0;
      done      <= 1'b0;
    end else begin
      m_ce <= adv;
      done <= 1'b0;
      case (state)
        IDLE:   if (!empty) state <= STREAM;
        STREAM: if (pop && fifo_rdata[VW]) begin
                  state     <= FLUSH;
                  flush_cnt <= CW'(NROWS - 1);
                end
        FLUSH:  if (stall_n) begin
                  if (flush_cnt == CW'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                  end else begin
                    flush_cnt <= flush_cnt - 1'b1;
                  end
                end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (push) stat_beats <= stat_beats + 1'b1;
      if (!stall_n && (state != IDLE) && (stat_stall != '1))
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder (NROWS=4, DATA_WIDTH=64, FIFO_DEPTH=4).
module tb_skew_feeder;
  localparam int NR = 4;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             s_valid, s_ready, s_last, stall_n;
  logic [NR*DW-1:0] s_data, m_data;
  logic [NR-1:0]    m_lane_valid;
  logic             m_ce, busy, done;
`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0]      stat_beats, stat_stall;
`endif

  skew_feeder #(.NROWS(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .stall_n      (stall_n),
    .m_data       (m_data),
    .m_lane_valid (m_lane_valid),
    .m_ce         (m_ce),
    .busy         (busy),
    .done         (done)
`ifdef SKEW_FEEDER_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_stall   (stat_stall)
`endif
  );

  typedef struct {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    vld;
    logic             dn;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ign = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [NR*DW-1:0] mk(input logic [63:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [NR*DW-1:0] d, input logic [NR-1:0] v, input logic dn, input int c);
    exp_t e;
    e.data = d; e.vld = v; e.dn = dn; e.cyc = c;
    q.push_back(e);
  endtask

  // called on a negedge; returns on the negedge after the accepting edge
  task automatic send(input logic [NR*DW-1:0] d, input logic l, output int acc);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!s_ready) begin errors++; $display("FAIL send_timeout s_ready=%b want=1", s_ready); end
    @(negedge clk);
    acc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk(name, 256'(q.size()), 256'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (aresetn && !ign && (m_ce || done)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output cyc=%0d m_ce=%b done=%b vld=%b", cyc, m_ce, done, m_lane_valid);
        end else begin
          e = q.pop_front();
          checks++;
          if (m_data !== e.data || m_lane_valid !== e.vld || done !== e.dn) begin
            errors++;
            $display("FAIL out_beat cyc=%0d got data=%0h vld=%b done=%b want data=%0h vld=%b done=%b",
                     cyc, m_data, m_lane_valid, done, e.data, e.vld, e.dn);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL out_cycle got=%0d want=%0d", cyc, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    int acc, accx, accy, nrel, n;
    logic [NR*DW-1:0] d;
    logic [NR-1:0] v;
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; stall_n = 1'b1;
    fork
      monitor();
      begin
        #1;
        chk("rst_m_data", m_data, '0);
        chk("rst_valid", 256'(m_lane_valid), '0);
        chk("rst_ce_done", {m_ce, done, busy}, '0);
        chk("rst_ready", 256'(s_ready), 256'd1);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);

        // single beat with last
        send(mk(64'h1, 64'h2, 64'h3, 64'h4), 1'b1, acc);
        push_exp(mk(64'h1, 0, 0, 0), 4'b0001, 1'b0, acc + 2);
        push_exp(mk(0, 64'h2, 0, 0), 4'b0010, 1'b0, acc + 3);
        push_exp(mk(0, 0, 64'h3, 0), 4'b0100, 1'b0, acc + 4);
        push_exp(mk(0, 0, 0, 64'h4), 4'b1000, 1'b1, acc + 5);
        drain("single_drain");
        @(negedge clk);
        chk("single_idle_busy", 256'(busy), 256'd0);

        // back-pressure: stalled array, FIFO fills after 4 beats
        stall_n = 1'b0;
        for (int b = 1; b <= 4; b++) begin
          s_valid = 1'b1; s_last = 1'b0;
          for (int i = 0; i < NR; i++) s_data[i*DW +: DW] = 64'(256 + 16*b + i);
          chk("bp_ready_open", 256'(s_ready), 256'd1);
          @(negedge clk);
        end
        for (int i = 0; i < NR; i++) s_data[i*DW +: DW] = 64'(256 + 16*5 + i);
        s_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
          chk("bp_ready_full", 256'(s_ready), 256'd0);
          chk("bp_ce_frozen", 256'(m_ce), 256'd0);
          chk("bp_data_frozen", m_data, mk(0, 0, 0, 64'h4));
          chk("bp_vld_frozen", 256'(m_lane_valid), 256'(4'b1000));
          @(negedge clk);
        end
        stall_n = 1'b1;
        nrel = cyc;
        for (int a = 1; a <= 8; a++) begin
          d = '0; v = '0;
          for (int i = 0; i < NR; i++)
            if (a - i >= 1 && a - i <= 5) begin
              d[i*DW +: DW] = 64'(256 + 16*(a - i) + i);
              v[i] = 1'b1;
            end
          push_exp(d, v, a == 8, nrel + a);
        end
        n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        drain("bp_drain");

        // stall in the middle of the flush
        send(mk(64'h11, 64'h22, 64'h33, 64'h44), 1'b1, acc);
        push_exp(mk(64'h11, 0, 0, 0), 4'b0001, 1'b0, acc + 2);
        push_exp(mk(0, 64'h22, 0, 0), 4'b0010, 1'b0, acc + 3);
        push_exp(mk(0, 0, 64'h33, 0), 4'b0100, 1'b0, acc + 5);
        push_exp(mk(0, 0, 0, 64'h44), 4'b1000, 1'b1, acc + 6);
        repeat (3) @(negedge clk);
        stall_n = 1'b0;
        @(negedge clk);
        chk("flush_stall_ce", {m_ce, done}, '0);
        stall_n = 1'b1;
        drain("flush_drain");

        // two beats with a 3-cycle gap, no last
        send(mk(64'h51, 64'h52, 64'h53, 64'h54), 1'b0, accx);
        push_exp(mk(64'h51, 0, 0, 0), 4'b0001, 1'b0, accx + 2);
        repeat (3) @(negedge clk);
        chk("gap_ce_a", 256'(m_ce), 256'd0);
        send(mk(64'h61, 64'h62, 64'h63, 64'h64), 1'b0, accy);
        push_exp(mk(64'h61, 64'h52, 0, 0), 4'b0011, 1'b0, accy + 2);
        chk("gap_ce_b", 256'(m_ce), 256'd0);
        @(negedge clk);
        chk("gap_ce_c", 256'(m_ce), 256'd0);
        drain("gap_drain");
        chk("gap_busy", 256'(busy), 256'd1);

        // reset in the middle of a stream
        ign = 1'b1;
        s_valid = 1'b1; s_data = mk(64'h71, 64'h72, 64'h73, 64'h74);
        repeat (3) @(negedge clk);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_data", m_data, '0);
        chk("mid_rst_ctrl", {m_lane_valid, m_ce, done, busy}, '0);
        chk("mid_rst_ready", 256'(s_ready), 256'd1);
        s_valid = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_state", {busy, m_ce, s_ready}, 256'd1);

`ifdef SKEW_FEEDER_STATS_EN
        chk("stats_rst", {stat_beats, stat_stall}, '0);
        send(mk(64'h81, 64'h82, 64'h83, 64'h84), 1'b0, acc);
        repeat (3) @(negedge clk);
        stall_n = 1'b0;
        s_valid = 1'b1;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        stall_n = 1'b1;
        send(mk(64'h91, 64'h92, 64'h93, 64'h94), 1'b1, acc);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("stats_done", 256'(done), 256'd1);
        chk("stats_beats", 256'(stat_beats), 256'd6);
        chk("stats_stall", 256'(stat_stall), 256'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end
endmodule
